// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU memory-port arbiter and its neighbours.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } arb_state_t;

    localparam logic [3:0]  BYTE_EN_ALL  = 4'b1111;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter
    import mips_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_address,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [31:0]       d_writedata,
    input  logic [3:0]        d_byteenable,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state, state_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       grant_fetch, grant_data, done;

    logic d_any, if_pend, d_pend, d_turn_hold;

    assign d_any   = d_read | d_write;
    // A requester whose valid is high is finishing; its request is not a new one yet.
    assign if_pend = if_req & ~if_valid;
    assign d_pend  = d_any & ~d_valid;

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_any & ~d_valid;

    // Data still asserted in its own valid cycle will be re-requested next cycle;
    // keep data priority across that turnaround unless fetch is due.
    assign d_turn_hold = d_valid & d_any & (starve_cnt < LIMIT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        grant_fetch    = 1'b0;
        grant_data     = 1'b0;
        done           = 1'b0;
        unique case (state)
            IDLE: begin
                // Raw if_req counts as waiting so a fetch re-request in its valid
                // cycle still accrues starvation credit.
                if (d_pend && (!if_req || starve_cnt < LIMIT)) begin
                    grant_data     = 1'b1;
                    state_nxt      = DATA;
                    starve_cnt_nxt = if_req ? starve_cnt + 4'd1 : 4'd0;
                end else if (if_pend && !d_turn_hold) begin
                    grant_fetch    = 1'b1;
                    state_nxt      = FETCH;
                    starve_cnt_nxt = 4'd0;
                end
            end
            FETCH, DATA: begin
                if (!mem_waitrequest) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            if_valid       <= 1'b0;
            d_valid        <= 1'b0;
            if_rdata       <= '0;
            d_rdata        <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (grant_data) begin
                mem_address    <= d_address;
                mem_write      <= d_write;
                mem_read       <= d_read & ~d_write;
                mem_writedata  <= d_writedata;
                mem_byteenable <= d_byteenable;
            end else if (grant_fetch) begin
                mem_address    <= if_address;
                mem_read       <= 1'b1;
                mem_write      <= 1'b0;
                mem_byteenable <= BYTE_EN_ALL;
            end

            if (done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                if (state == FETCH) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_readdata;
                end else begin
                    d_valid <= 1'b1;
                    if (mem_read) d_rdata <= mem_readdata;
                end
            end
        end
    end

endmodule
